// File: rtl/fifo_level.sv
// fifo_level: single-clock FIFO with occupancy count, almost/full/empty
// status, sticky overflow/underflow flags, and a selectable read mode
// (first-word-fall-through or registered read).
//
// Handshake: a write happens on a rising edge exactly when
// wvalid_i && wready_o. A pop happens exactly when rready_i is high and
// the FIFO is not empty. In FWFT mode that is rready_i && rvalid_o. In
// registered mode, rvalid_o marks the single cycle after a pop in which
// data_o carries the popped word. clear_i overrides both transfers.
module fifo_level #(
    parameter int DataWidth      = 8,
    parameter int Depth          = 16,
    parameter int AlmostFullThr  = 14,
    parameter int AlmostEmptyThr = 2,
    parameter int Fwft           = 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       clear_i,
    input  logic                       wvalid_i,
    output logic                       wready_o,
    input  logic [DataWidth-1:0]       data_i,
    input  logic                       rready_i,
    output logic                       rvalid_o,
    output logic [DataWidth-1:0]       data_o,
    output logic [$clog2(Depth):0]     count_o,
    output logic                       is_full_o,
    output logic                       is_empty_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int AW = $clog2(Depth);
    localparam int PW = AW + 1;

    // Pointers carry one extra wrap bit so full and empty stay distinct.
    logic [PW-1:0]        wptr_q;
    logic [PW-1:0]        rptr_q;
    logic [DataWidth-1:0] mem_q [Depth];
    logic                 overflow_q;
    logic                 underflow_q;
    logic                 wr_en;
    logic                 rd_en;

    assign count_o        = wptr_q - rptr_q;
    assign is_full_o      = (count_o == PW'(Depth));
    assign is_empty_o     = (count_o == '0);
    assign wready_o       = !is_full_o;
    assign almost_full_o  = (count_o >= PW'(AlmostFullThr));
    assign almost_empty_o = (count_o <= PW'(AlmostEmptyThr));
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

    // A full FIFO refuses the write even if a pop happens in the same cycle.
    assign wr_en = wvalid_i && !is_full_o && !clear_i;
    assign rd_en = rready_i && !is_empty_o && !clear_i;

    // Pointer update; clear_i flushes by zeroing both pointers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (clear_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (rd_en) rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage write; the array is not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

    // Sticky error flags, cleared only by clear_i or reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clear_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wvalid_i && !wready_o) overflow_q  <= 1'b1;
            if (rready_i && is_empty_o) underflow_q <= 1'b1;
        end
    end

    generate
        if (Fwft != 0) begin : g_fwft
            // Head entry is presented combinationally whenever data is stored.
            assign rvalid_o = !is_empty_o;
            assign data_o   = mem_q[rptr_q[AW-1:0]];
        end else begin : g_reg
            logic                 rvalid_q;
            logic [DataWidth-1:0] data_q;

            // Registered read: capture the popped word, valid for one cycle.
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    rvalid_q <= 1'b0;
                    data_q   <= '0;
                end else if (clear_i) begin
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_en;
                    if (rd_en) data_q <= mem_q[rptr_q[AW-1:0]];
                end
            end

            assign rvalid_o = rvalid_q;
            assign data_o   = data_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_level.sv
// tb_fifo_level: directed checks of fifo_level in FWFT (instance a) and
// registered-read (instance b) modes.
module tb_fifo_level;

    logic clk;
    int   n_vec;
    int   n_err;

    // FWFT instance signals
    logic       a_rst, a_clr, a_wvalid, a_wready, a_rready, a_rvalid;
    logic [7:0] a_wdata, a_dout;
    logic [4:0] a_count;
    logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;

    // Registered-read instance signals
    logic       b_rst, b_clr, b_wvalid, b_wready, b_rready, b_rvalid;
    logic [7:0] b_wdata, b_dout;
    logic [4:0] b_count;
    logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;

    fifo_level u_fwft (
        .clk_i(clk), .reset_i(a_rst), .clear_i(a_clr),
        .wvalid_i(a_wvalid), .wready_o(a_wready), .data_i(a_wdata),
        .rready_i(a_rready), .rvalid_o(a_rvalid), .data_o(a_dout),
        .count_o(a_count), .is_full_o(a_full), .is_empty_o(a_empty),
        .almost_full_o(a_af), .almost_empty_o(a_ae),
        .overflow_o(a_ovf), .underflow_o(a_unf)
    );

    fifo_level #(.Fwft(0)) u_reg (
        .clk_i(clk), .reset_i(b_rst), .clear_i(b_clr),
        .wvalid_i(b_wvalid), .wready_o(b_wready), .data_i(b_wdata),
        .rready_i(b_rready), .rvalid_o(b_rvalid), .data_o(b_dout),
        .count_o(b_count), .is_full_o(b_full), .is_empty_o(b_empty),
        .almost_full_o(b_af), .almost_empty_o(b_ae),
        .overflow_o(b_ovf), .underflow_o(b_unf)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 1'b0; b_rst = 1'b0;
        a_clr = 0; a_wvalid = 0; a_rready = 0; a_wdata = '0;
        b_clr = 0; b_wvalid = 0; b_rready = 0; b_wdata = '0;
        #1;
        a_rst = 1'b1; b_rst = 1'b1;
        #1;
        n_vec++; if (a_count !== 5'd0 || a_empty !== 1'b1 || a_full !== 1'b0 || a_wready !== 1'b1)
            begin n_err++; $display("FAIL reset_a_level: count=%0d empty=%b full=%b wready=%b want 0 1 0 1", a_count, a_empty, a_full, a_wready); end
        n_vec++; if (a_rvalid !== 1'b0 || a_ae !== 1'b1 || a_af !== 1'b0 || a_ovf !== 1'b0 || a_unf !== 1'b0)
            begin n_err++; $display("FAIL reset_a_flags: rvalid=%b ae=%b af=%b ovf=%b unf=%b want 0 1 0 0 0", a_rvalid, a_ae, a_af, a_ovf, a_unf); end
        n_vec++; if (b_dout !== 8'h00 || b_rvalid !== 1'b0 || b_count !== 5'd0 || b_empty !== 1'b1)
            begin n_err++; $display("FAIL reset_b: dout=%h rvalid=%b count=%0d empty=%b want 00 0 0 1", b_dout, b_rvalid, b_count, b_empty); end
        tick(); tick();
        #2;
        a_rst = 1'b0; b_rst = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            a_wvalid = 1'b1; a_wdata = 8'(i);
            tick();
            n_vec++; if (a_count !== 5'(i + 1) || a_af !== ((i + 1) >= 14))
                begin n_err++; $display("FAIL fill_step%0d: count=%0d af=%b want %0d %b", i, a_count, a_af, i + 1, ((i + 1) >= 14)); end
        end
        n_vec++; if (a_full !== 1'b1 || a_wready !== 1'b0 || a_ovf !== 1'b0)
            begin n_err++; $display("FAIL fill_full: full=%b wready=%b ovf=%b want 1 0 0", a_full, a_wready, a_ovf); end
        a_wdata = 8'hEE;
        tick();
        a_wvalid = 1'b0;
        n_vec++; if (a_count !== 5'd16 || a_ovf !== 1'b1)
            begin n_err++; $display("FAIL fill_overflow: count=%0d ovf=%b want 16 1", a_count, a_ovf); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            n_vec++; if (a_rvalid !== 1'b1 || a_dout !== 8'(i) || a_ae !== ((16 - i) <= 2))
                begin n_err++; $display("FAIL drain_word%0d: rvalid=%b data=%h ae=%b want 1 %h %b", i, a_rvalid, a_dout, a_ae, 8'(i), ((16 - i) <= 2)); end
            a_rready = 1'b1;
            tick();
        end
        n_vec++; if (a_empty !== 1'b1 || a_count !== 5'd0 || a_ae !== 1'b1 || a_unf !== 1'b0)
            begin n_err++; $display("FAIL drain_empty: empty=%b count=%0d ae=%b unf=%b want 1 0 1 0", a_empty, a_count, a_ae, a_unf); end
        tick();
        a_rready = 1'b0;
        n_vec++; if (a_unf !== 1'b1 || a_ovf !== 1'b1)
            begin n_err++; $display("FAIL drain_underflow: unf=%b ovf=%b want 1 1", a_unf, a_ovf); end
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        n_vec++; if (a_unf !== 1'b0 || a_ovf !== 1'b0 || a_count !== 5'd0)
            begin n_err++; $display("FAIL drain_clear: unf=%b ovf=%b count=%0d want 0 0 0", a_unf, a_ovf, a_count); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            a_wvalid = 1'b1; a_wdata = 8'(100 + i);
            tick();
        end
        for (int i = 0; i < 40; i++) begin
            n_vec++; if (a_rvalid !== 1'b1 || a_dout !== 8'(100 + i))
                begin n_err++; $display("FAIL stream_data%0d: rvalid=%b data=%0d want 1 %0d", i, a_rvalid, a_dout, 100 + i); end
            a_wvalid = 1'b1; a_wdata = 8'(103 + i); a_rready = 1'b1;
            tick();
            n_vec++; if (a_count !== 5'd3)
                begin n_err++; $display("FAIL stream_count%0d: count=%0d want 3", i, a_count); end
        end
        a_wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (a_dout !== 8'(140 + i))
                begin n_err++; $display("FAIL stream_tail%0d: data=%0d want %0d", i, a_dout, 140 + i); end
            tick();
        end
        a_rready = 1'b0;
        n_vec++; if (a_count !== 5'd0 || a_unf !== 1'b0)
            begin n_err++; $display("FAIL stream_end: count=%0d unf=%b want 0 0", a_count, a_unf); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) begin
            a_wvalid = 1'b1; a_wdata = 8'(200 + i);
            tick();
        end
        a_wdata = 8'h77; a_rready = 1'b1;
        tick();
        a_wvalid = 1'b0;
        n_vec++; if (a_count !== 5'd15 || a_full !== 1'b0 || a_ovf !== 1'b1)
            begin n_err++; $display("FAIL full_both: count=%0d full=%b ovf=%b want 15 0 1", a_count, a_full, a_ovf); end
        for (int i = 1; i < 16; i++) begin
            n_vec++; if (a_dout !== 8'(200 + i))
                begin n_err++; $display("FAIL full_both_order%0d: data=%0d want %0d", i, a_dout, 200 + i); end
            tick();
        end
        a_rready = 1'b0;
        n_vec++; if (a_empty !== 1'b1)
            begin n_err++; $display("FAIL full_both_refused: empty=%b want 1", a_empty); end
        a_wvalid = 1'b1; a_wdata = 8'h3C; a_rready = 1'b1;
        tick();
        a_wvalid = 1'b0; a_rready = 1'b0;
        n_vec++; if (a_count !== 5'd1 || a_rvalid !== 1'b1 || a_dout !== 8'h3C)
            begin n_err++; $display("FAIL empty_both: count=%0d rvalid=%b data=%h want 1 1 3c", a_count, a_rvalid, a_dout); end
        a_rready = 1'b1;
        tick();
        a_rready = 1'b0;
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
    endtask

    task automatic test_registered();
        b_wvalid = 1'b1; b_wdata = 8'hA5;
        tick();
        b_wvalid = 1'b0;
        n_vec++; if (b_rvalid !== 1'b0 || b_count !== 5'd1 || b_dout !== 8'h00)
            begin n_err++; $display("FAIL reg_write: rvalid=%b count=%0d data=%h want 0 1 00", b_rvalid, b_count, b_dout); end
        b_rready = 1'b1;
        tick();
        b_rready = 1'b0;
        n_vec++; if (b_rvalid !== 1'b1 || b_dout !== 8'hA5 || b_count !== 5'd0)
            begin n_err++; $display("FAIL reg_pop: rvalid=%b data=%h count=%0d want 1 a5 0", b_rvalid, b_dout, b_count); end
        tick();
        n_vec++; if (b_rvalid !== 1'b0 || b_dout !== 8'hA5 || b_unf !== 1'b0)
            begin n_err++; $display("FAIL reg_hold: rvalid=%b data=%h unf=%b want 0 a5 0", b_rvalid, b_dout, b_unf); end
        b_rready = 1'b1;
        tick();
        b_rready = 1'b0;
        n_vec++; if (b_unf !== 1'b1 || b_rvalid !== 1'b0)
            begin n_err++; $display("FAIL reg_underflow: unf=%b rvalid=%b want 1 0", b_unf, b_rvalid); end
        #2;
        b_rst = 1'b1;
        #1;
        n_vec++; if (b_dout !== 8'h00 || b_rvalid !== 1'b0 || b_unf !== 1'b0 || b_empty !== 1'b1)
            begin n_err++; $display("FAIL reg_async_reset: data=%h rvalid=%b unf=%b empty=%b want 00 0 0 1", b_dout, b_rvalid, b_unf, b_empty); end
        b_rst = 1'b0;
        tick();
    endtask

    task automatic test_clear_reset();
        for (int i = 0; i < 17; i++) begin
            a_wvalid = 1'b1; a_wdata = 8'(i);
            tick();
        end
        a_wvalid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            a_rready = 1'b1;
            tick();
        end
        a_rready = 1'b0;
        n_vec++; if (a_count !== 5'd5 || a_ovf !== 1'b1 || a_dout !== 8'd11)
            begin n_err++; $display("FAIL cr_setup: count=%0d ovf=%b data=%0d want 5 1 11", a_count, a_ovf, a_dout); end
        a_clr = 1'b1; a_wvalid = 1'b1; a_wdata = 8'h55;
        tick();
        a_clr = 1'b0;
        n_vec++; if (a_count !== 5'd0 || a_ovf !== 1'b0 || a_empty !== 1'b1)
            begin n_err++; $display("FAIL cr_clear: count=%0d ovf=%b empty=%b want 0 0 1", a_count, a_ovf, a_empty); end
        tick();
        n_vec++; if (a_count !== 5'd1)
            begin n_err++; $display("FAIL cr_midwrite: count=%0d want 1", a_count); end
        #2;
        a_rst = 1'b1;
        #1;
        n_vec++; if (a_count !== 5'd0 || a_empty !== 1'b1 || a_full !== 1'b0 || a_wready !== 1'b1 || a_rvalid !== 1'b0)
            begin n_err++; $display("FAIL cr_reset_level: count=%0d empty=%b full=%b wready=%b rvalid=%b want 0 1 0 1 0", a_count, a_empty, a_full, a_wready, a_rvalid); end
        n_vec++; if (a_ae !== 1'b1 || a_af !== 1'b0 || a_ovf !== 1'b0 || a_unf !== 1'b0)
            begin n_err++; $display("FAIL cr_reset_flags: ae=%b af=%b ovf=%b unf=%b want 1 0 0 0", a_ae, a_af, a_ovf, a_unf); end
        a_wvalid = 1'b0;
        a_rst = 1'b0;
        tick();
        a_wvalid = 1'b1; a_wdata = 8'h42;
        tick();
        a_wvalid = 1'b0;
        n_vec++; if (a_count !== 5'd1 || a_rvalid !== 1'b1 || a_dout !== 8'h42)
            begin n_err++; $display("FAIL cr_after_reset: count=%0d rvalid=%b data=%h want 1 1 42", a_count, a_rvalid, a_dout); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_simultaneous();
        test_registered();
        test_clear_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_level.md
FIFO_LEVEL -- requirements
Module: fifo_level

Interface
REQ-001 SHALL have parameter DataWidth, default 8, payload width in bits (>=1).
REQ-002 SHALL have parameter Depth, default 16, storage entries; power of two, >=2.
REQ-003 SHALL have parameter AlmostFullThr, default 14, almost_full_o threshold; legal range 1..Depth.
REQ-004 SHALL have parameter AlmostEmptyThr, default 2, almost_empty_o threshold; legal range 0..Depth-1.
REQ-005 SHALL have parameter Fwft, default 1, read mode: 1 = first-word-fall-through, 0 = registered read.
REQ-006 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port reset_i  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port clear_i  input  1  synchronous flush.
REQ-009 SHALL have port wvalid_i  input  1  write request.
REQ-010 SHALL have port wready_o  output  1  FIFO can accept a write.
REQ-011 SHALL have port data_i  input  DataWidth  write data.
REQ-012 SHALL have port rready_i  input  1  read request/accept.
REQ-013 SHALL have port rvalid_o  output  1  data_o valid.
REQ-014 SHALL have port data_o  output  DataWidth  read data.
REQ-015 SHALL have port count_o  output  $clog2(Depth)+1  current occupancy, 0..Depth.
REQ-016 SHALL have ports is_full_o, is_empty_o, almost_full_o, almost_empty_o  output  1 each  status flags.
REQ-017 SHALL have ports overflow_o, underflow_o  output  1 each  sticky error flags.

Function
REQ-018 SHALL accept a write on a rising edge iff wvalid_i && wready_o; wready_o = !is_full_o, combinational from registered state.
REQ-019 SHALL use read/write pointers of $clog2(Depth)+1 bits, wrapping modulo 2*Depth; count_o = wptr - rptr; full when count_o == Depth, empty when count_o == 0.
REQ-020 Fwft=1: SHALL drive rvalid_o = !is_empty_o, data_o = head entry; pop on rising edge iff rready_i && rvalid_o; a word written at edge N SHALL appear on data_o after edge N with rvalid_o high.
REQ-021 Fwft=0: SHALL pop on rising edge iff rready_i && !is_empty_o; data_o and rvalid_o registered, rvalid_o high for exactly the cycle after each pop, data_o holding its last value otherwise.
REQ-022 SHALL update count_o by +1 (write only), -1 (pop only), 0 (both or neither) per edge.
REQ-023 Full + simultaneous write and pop: write SHALL be refused (no bypass); count_o goes Depth-1.
REQ-024 Empty + simultaneous write and read request: write SHALL be accepted, no pop; count_o goes 1.
REQ-025 SHALL derive almost_full_o = (count_o >= AlmostFullThr) and almost_empty_o = (count_o <= AlmostEmptyThr), updating on the same edge as count_o.
REQ-026 SHALL set overflow_o on the edge where wvalid_i && !wready_o; sticky until clear_i or reset.
REQ-027 SHALL set underflow_o on the edge where rready_i is high while empty (Fwft=1: rready_i && !rvalid_o); sticky until clear_i or reset.
REQ-028 SHALL preserve data order exactly; no loss or duplication across pointer wrap-around.
REQ-029 clear_i SHALL zero pointers, count_o, rvalid_o (Fwft=0), overflow_o and underflow_o on the next edge, overriding any write or pop that cycle; memory contents need not be cleared.

Reset
REQ-030 reset_i high SHALL immediately, without a clock, force: pointers 0, count_o 0, is_empty_o 1, is_full_o 0, wready_o 1, rvalid_o 0, data_o 0 (Fwft=0), almost_empty_o 1, almost_full_o 0, overflow_o 0, underflow_o 0.
REQ-031 Reset asserted mid-transfer SHALL discard all stored data; first edge after deassertion SHALL behave as from empty.
REQ-032 Storage array SHALL not require reset.

Verification
REQ-033 Defaults, Fwft=1: write 16 words 0..15 -> is_full_o=1, count_o=16, almost_full_o=1 from count 14; 17th write -> refused, overflow_o=1.
REQ-034 Read 16 words -> data_o sequence 0..15, is_empty_o=1 after last pop, almost_empty_o=1 from count 2; extra rready_i -> underflow_o=1.
REQ-035 Continuous simultaneous write/read for 40 cycles from count 3 -> count_o stays 3, data in order across wrap-around.
REQ-036 Fwft=0: write 0xA5, pulse rready_i one cycle -> rvalid_o high exactly the next cycle with data_o=0xA5.
REQ-037 Full FIFO, assert wvalid_i and rready_i together -> count_o=15, write refused; empty FIFO same -> count_o=1, no pop.
REQ-038 Count 5 with overflow_o=1: pulse clear_i with wvalid_i high -> count_o=0, overflow_o=0; then assert reset_i mid-write -> all outputs at REQ-030 values asynchronously.
